// File: rtl/ps2_entry_pkg.sv
// rtl/ps2_entry_pkg.sv - scan-code constants, parser states and digit decode for the PS/2 digit entry block
package ps2_entry_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_BRK,
        PS_EXT,
        PS_EXT_BRK
    } parse_state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] value;
    } digit_dec_t;

    // Top-row and keypad digits share one decode; anything else reports is_digit=0.
    function automatic digit_dec_t decode_digit(input logic [7:0] code);
        digit_dec_t r;
        r.is_digit = 1'b1;
        case (code)
            8'h45, 8'h70: r.value = 4'd0;
            8'h16, 8'h69: r.value = 4'd1;
            8'h1E, 8'h72: r.value = 4'd2;
            8'h26, 8'h7A: r.value = 4'd3;
            8'h25, 8'h6B: r.value = 4'd4;
            8'h2E, 8'h73: r.value = 4'd5;
            8'h36, 8'h74: r.value = 4'd6;
            8'h3D, 8'h6C: r.value = 4'd7;
            8'h3E, 8'h75: r.value = 4'd8;
            8'h46, 8'h7D: r.value = 4'd9;
            default: begin
                r.is_digit = 1'b0;
                r.value    = 4'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_digit_entry_if.sv
// rtl/ps2_digit_entry_if.sv - key stream, mode controls and entry results of the digit entry block
interface ps2_digit_entry_if #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_MODES  = 7
);
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int MODE_W = $clog2(NUM_MODES + 1);

    logic [7:0]              key_data;
    logic                    key_valid;
    logic                    check_duration;
    logic                    check_load;
    logic                    select_auto;
    logic [4*NUM_DIGITS-1:0] duration_out;
    logic [CNT_W-1:0]        digit_count;
    logic [MODE_W-1:0]       auto_mode;
    logic                    enter_pressed;
    logic                    auto_set;
    logic                    valid_key;
    logic                    overflow;

    modport master (
        output key_data, key_valid, check_duration, check_load, select_auto,
        input  duration_out, digit_count, auto_mode, enter_pressed, auto_set, valid_key, overflow
    );

    modport slave (
        input  key_data, key_valid, check_duration, check_load, select_auto,
        output duration_out, digit_count, auto_mode, enter_pressed, auto_set, valid_key, overflow
    );

endinterface

// File: rtl/ps2_scan_parser.sv
// rtl/ps2_scan_parser.sv - PS/2 set-2 prefix parser with typematic repeat suppression
module ps2_scan_parser
    import ps2_entry_pkg::*;
#(
    parameter int REPEAT_FILTER = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic       make_strobe,
    output logic       break_strobe,
    output logic [7:0] code,
    output logic       extended
);

    parse_state_t state_q, state_d;
    logic         raw_make;
    logic         raw_break;
    logic         held_valid_q;
    logic [8:0]   held_key_q;
    logic         key_matches_held;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        raw_make  = 1'b0;
        raw_break = 1'b0;
        extended  = 1'b0;
        if (key_valid) begin
            case (state_q)
                PS_IDLE: begin
                    if (key_data == SC_BREAK)       state_d = PS_BRK;
                    else if (key_data == SC_EXTEND) state_d = PS_EXT;
                    else                            raw_make = 1'b1;
                end
                PS_EXT: begin
                    extended = 1'b1;
                    if (key_data == SC_BREAK) begin
                        state_d = PS_EXT_BRK;
                    end else begin
                        raw_make = 1'b1;
                        state_d  = PS_IDLE;
                    end
                end
                PS_BRK: begin
                    raw_break = 1'b1;
                    state_d   = PS_IDLE;
                end
                PS_EXT_BRK: begin
                    extended  = 1'b1;
                    raw_break = 1'b1;
                    state_d   = PS_IDLE;
                end
                default: state_d = PS_IDLE;
            endcase
        end
    end

    assign code             = key_data;
    assign key_matches_held = held_valid_q && (held_key_q == {extended, key_data});
    assign make_strobe      = raw_make && !((REPEAT_FILTER != 0) && key_matches_held);
    assign break_strobe     = raw_break;

    // Only the most recent accepted make is remembered; releasing any other key leaves it armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_key_q   <= 9'd0;
        end else if (make_strobe) begin
            held_valid_q <= 1'b1;
            held_key_q   <= {extended, key_data};
        end else if (raw_break && key_matches_held) begin
            held_valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_digit_entry.sv
// rtl/ps2_digit_entry.sv - BCD duration entry and auto-mode selection from PS/2 key strokes
module ps2_digit_entry
    import ps2_entry_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int NUM_MODES     = 7,
    parameter int REPEAT_FILTER = 1
) (
    input  logic               clock,
    input  logic               reset,
    ps2_digit_entry_if.slave   bus
);

    localparam int MODE_W = $clog2(NUM_MODES + 1);
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);

    logic                    make_strobe;
    logic                    break_strobe;
    logic [7:0]              code;
    logic                    extended;
    digit_dec_t              dig;
    logic                    is_digit, is_bksp, is_esc, is_enter, mode_ok;
    logic [4*NUM_DIGITS-1:0] duration_q;
    logic [CNT_W-1:0]        count_q;
    logic [MODE_W-1:0]       mode_q;
    logic                    enter_q, auto_set_q, valid_key_q, overflow_q;

    ps2_scan_parser #(
        .REPEAT_FILTER (REPEAT_FILTER)
    ) u_parser (
        .clock        (clock),
        .reset        (reset),
        .key_data     (bus.key_data),
        .key_valid    (bus.key_valid),
        .make_strobe  (make_strobe),
        .break_strobe (break_strobe),
        .code         (code),
        .extended     (extended)
    );

    always_comb assert (!(make_strobe && break_strobe));

    // Digits, Backspace and Escape come from the main block only; Enter exists in both forms.
    assign dig      = decode_digit(code);
    assign is_digit = make_strobe && !extended && dig.is_digit;
    assign is_bksp  = make_strobe && !extended && (code == SC_BKSP);
    assign is_esc   = make_strobe && !extended && (code == SC_ESC);
    assign is_enter = make_strobe && (code == SC_ENTER);
    assign mode_ok  = (dig.value != 4'd0) && (32'(dig.value) <= NUM_MODES);

    always_ff @(posedge clock) begin
        if (reset) begin
            duration_q  <= '0;
            count_q     <= '0;
            mode_q      <= '0;
            enter_q     <= 1'b0;
            auto_set_q  <= 1'b0;
            valid_key_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            enter_q     <= is_enter && (bus.check_duration || bus.check_load);
            auto_set_q  <= 1'b0;
            valid_key_q <= 1'b0;
            overflow_q  <= 1'b0;
            if (bus.select_auto) begin
                if (is_digit && mode_ok) begin
                    mode_q     <= MODE_W'(dig.value);
                    auto_set_q <= 1'b1;
                end else if (is_esc) begin
                    duration_q <= '0;
                    count_q    <= '0;
                    mode_q     <= '0;
                end
            end else if (bus.check_duration) begin
                if (is_digit) begin
                    if (count_q != FULL) begin
                        duration_q  <= {duration_q[4*NUM_DIGITS-5:0], dig.value};
                        count_q     <= count_q + 1'b1;
                        valid_key_q <= 1'b1;
                    end else begin
                        overflow_q  <= 1'b1;
                    end
                end else if (is_bksp && (count_q != '0)) begin
                    duration_q <= {4'd0, duration_q[4*NUM_DIGITS-1:4]};
                    count_q    <= count_q - 1'b1;
                end else if (is_esc) begin
                    duration_q <= '0;
                    count_q    <= '0;
                    mode_q     <= '0;
                end
            end
        end
    end

    assign bus.duration_out  = duration_q;
    assign bus.digit_count   = count_q;
    assign bus.auto_mode     = mode_q;
    assign bus.enter_pressed = enter_q;
    assign bus.auto_set      = auto_set_q;
    assign bus.valid_key     = valid_key_q;
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// tb/tb_ps2_digit_entry.sv - scoreboard bench for ps2_digit_entry, filtered and unfiltered instances
module tb_ps2_digit_entry;

    localparam int ND = 4;
    localparam int NM = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_digit_entry_if #(.NUM_DIGITS(ND), .NUM_MODES(NM)) bus_f ();
    ps2_digit_entry_if #(.NUM_DIGITS(ND), .NUM_MODES(NM)) bus_n ();

    assign bus_n.key_data       = bus_f.key_data;
    assign bus_n.key_valid      = bus_f.key_valid;
    assign bus_n.check_duration = bus_f.check_duration;
    assign bus_n.check_load     = bus_f.check_load;
    assign bus_n.select_auto    = bus_f.select_auto;

    ps2_digit_entry #(.NUM_DIGITS(ND), .NUM_MODES(NM), .REPEAT_FILTER(1)) dut_f (
        .clock (clock), .reset (reset), .bus (bus_f));
    ps2_digit_entry #(.NUM_DIGITS(ND), .NUM_MODES(NM), .REPEAT_FILTER(0)) dut_n (
        .clock (clock), .reset (reset), .bus (bus_n));

    typedef struct {
        int pulses;
        int dur;
        int cnt;
        int mode;
    } exp_t;

    exp_t q_f[$];
    exp_t q_n[$];
    int   errors = 0;
    int   checks = 0;
    int   vk_cnt[2], ov_cnt[2], as_cnt[2], en_cnt[2];

    int   m_val[2], m_cnt[2], m_mode[2], m_held[2];
    bit   p_ext, p_brk;
    int   top_row[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    int   keypad[10]  = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bcd(input int v);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int code);
        for (int i = 0; i < 10; i++)
            if (top_row[i] == code || keypad[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_val[v] = 0; m_cnt[v] = 0; m_mode[v] = 0; m_held[v] = -1;
        end
        p_ext = 0;
        p_brk = 0;
    endtask

    task automatic model_make(input int v, input bit ext, input int code);
        int key = ext * 256 + code;
        int d   = ext ? -1 : digit_of(code);
        int pulses = 0;
        exp_t e;
        if (v == 0 && m_held[v] == key) return;
        m_held[v] = key;
        if (code == 'h5A && (bus_f.check_duration || bus_f.check_load)) pulses |= 8;
        if (bus_f.select_auto) begin
            if (d >= 1 && d <= NM) begin
                m_mode[v] = d;
                pulses |= 4;
            end else if (!ext && code == 'h76) begin
                m_val[v] = 0; m_cnt[v] = 0; m_mode[v] = 0;
            end
        end else if (bus_f.check_duration) begin
            if (d >= 0) begin
                if (m_cnt[v] < ND) begin
                    m_val[v] = m_val[v] * 10 + d;
                    m_cnt[v]++;
                    pulses |= 2;
                end else begin
                    pulses |= 1;
                end
            end else if (!ext && code == 'h66) begin
                if (m_cnt[v] > 0) begin
                    m_val[v] = m_val[v] / 10;
                    m_cnt[v]--;
                end
            end else if (!ext && code == 'h76) begin
                m_val[v] = 0; m_cnt[v] = 0; m_mode[v] = 0;
            end
        end
        if (pulses != 0) begin
            e = '{pulses: pulses, dur: bcd(m_val[v]), cnt: m_cnt[v], mode: m_mode[v]};
            if (v == 0) q_f.push_back(e);
            else        q_n.push_back(e);
        end
    endtask

    task automatic model_byte(input int b);
        if (p_brk) begin
            for (int v = 0; v < 2; v++)
                if (m_held[v] == p_ext * 256 + b) m_held[v] = -1;
            p_brk = 0;
            p_ext = 0;
        end else if (b == 'hF0) begin
            p_brk = 1;
        end else if (b == 'hE0 && !p_ext) begin
            p_ext = 1;
        end else begin
            model_make(0, p_ext, b);
            model_make(1, p_ext, b);
            p_ext = 0;
        end
    endtask

    task automatic send_byte(input int b);
        bus_f.key_data  = 8'(b);
        bus_f.key_valid = 1'b1;
        model_byte(b);
        @(posedge clock); #1;
        bus_f.key_valid = 1'b0;
        bus_f.key_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic set_ctrl(input bit sa, input bit cd, input bit cl);
        bus_f.select_auto    = sa;
        bus_f.check_duration = cd;
        bus_f.check_load     = cl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        idle(2);
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " f dur"},  32'(bus_f.duration_out), bcd(m_val[0]));
        chk({tag, " f cnt"},  32'(bus_f.digit_count),  m_cnt[0]);
        chk({tag, " f mode"}, 32'(bus_f.auto_mode),    m_mode[0]);
        chk({tag, " n dur"},  32'(bus_n.duration_out), bcd(m_val[1]));
        chk({tag, " n cnt"},  32'(bus_n.digit_count),  m_cnt[1]);
        chk({tag, " n mode"}, 32'(bus_n.auto_mode),    m_mode[1]);
    endtask

    task automatic observe(input int v, input logic [3:0] p, input logic [15:0] d,
                           input logic [2:0] c, input logic [2:0] m);
        exp_t  e;
        string tag = (v == 0) ? "filt" : "nofilt";
        if (p == 4'd0) return;
        vk_cnt[v] += int'(p[1]);
        ov_cnt[v] += int'(p[0]);
        as_cnt[v] += int'(p[2]);
        en_cnt[v] += int'(p[3]);
        if ((v == 0 && q_f.size() == 0) || (v == 1 && q_n.size() == 0)) begin
            chk({tag, " unexpected pulse"}, 32'(p), 0);
            return;
        end
        e = (v == 0) ? q_f.pop_front() : q_n.pop_front();
        chk({tag, " pulses"}, 32'(p), e.pulses);
        chk({tag, " duration"}, 32'(d), e.dur);
        chk({tag, " count"}, 32'(c), e.cnt);
        chk({tag, " mode"}, 32'(m), e.mode);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            observe(0, {bus_f.enter_pressed, bus_f.auto_set, bus_f.valid_key, bus_f.overflow},
                    bus_f.duration_out, bus_f.digit_count, bus_f.auto_mode);
            observe(1, {bus_n.enter_pressed, bus_n.auto_set, bus_n.valid_key, bus_n.overflow},
                    bus_n.duration_out, bus_n.digit_count, bus_n.auto_mode);
        end
    end

    int base_vk, base_vk_n, base_ov, base_as, base_en;
    int pool[$];

    initial begin
        bus_f.key_data  = 8'h00;
        bus_f.key_valid = 1'b0;
        set_ctrl(0, 0, 0);
        for (int v = 0; v < 2; v++) begin
            vk_cnt[v] = 0; ov_cnt[v] = 0; as_cnt[v] = 0; en_cnt[v] = 0;
        end
        do_reset();

        chk("reset dur",   32'(bus_f.duration_out), 0);
        chk("reset cnt",   32'(bus_f.digit_count), 0);
        chk("reset mode",  32'(bus_f.auto_mode), 0);
        chk("reset pulses", 32'({bus_f.enter_pressed, bus_f.auto_set, bus_f.valid_key, bus_f.overflow}), 0);

        // Two keys with releases in between
        set_ctrl(0, 1, 0);
        base_vk = vk_cnt[0];
        foreach (top_row[i]) if (0) ;
        send_byte('h16); send_byte('hF0); send_byte('h16);
        send_byte('h1E); send_byte('hF0); send_byte('h1E);
        idle(2);
        chk("two digits dur", 32'(bus_f.duration_out), 'h0012);
        chk("two digits cnt", 32'(bus_f.digit_count), 2);
        chk("two digits valid_key", vk_cnt[0] - base_vk, 2);

        // Fill past capacity, then backspace
        do_reset();
        set_ctrl(0, 1, 0);
        base_ov = ov_cnt[0];
        send_byte('h16); send_byte('h1E); send_byte('h26); send_byte('h25); send_byte('h2E);
        idle(2);
        chk("full dur", 32'(bus_f.duration_out), 'h1234);
        chk("full overflow", ov_cnt[0] - base_ov, 1);
        send_byte('h66);
        idle(2);
        chk("bksp dur", 32'(bus_f.duration_out), 'h0123);
        chk("bksp cnt", 32'(bus_f.digit_count), 3);

        // Auto mode selection, out-of-range digit ignored
        do_reset();
        set_ctrl(1, 0, 0);
        base_as = as_cnt[0];
        send_byte('h26); send_byte('h3E);
        idle(2);
        chk("auto mode", 32'(bus_f.auto_mode), 3);
        chk("auto_set count", as_cnt[0] - base_as, 1);
        chk("auto dur", 32'(bus_f.duration_out), 0);

        // Typematic repeats
        do_reset();
        set_ctrl(0, 1, 0);
        base_vk = vk_cnt[0];
        base_vk_n = vk_cnt[1];
        send_byte('h16); send_byte('h16); send_byte('h16); send_byte('hF0); send_byte('h16);
        idle(2);
        chk("repeat filt dur", 32'(bus_f.duration_out), 'h0001);
        chk("repeat filt valid_key", vk_cnt[0] - base_vk, 1);
        chk("repeat nofilt dur", 32'(bus_n.duration_out), 'h0111);
        chk("repeat nofilt valid_key", vk_cnt[1] - base_vk_n, 3);

        // Extended Enter timing, and its release producing nothing
        do_reset();
        set_ctrl(0, 0, 1);
        base_en = en_cnt[0];
        send_byte('hE0);
        send_byte('h5A);
        chk("enter one cycle after", 32'(bus_f.enter_pressed), 1);
        idle(1);
        chk("enter single cycle", 32'(bus_f.enter_pressed), 0);
        send_byte('hE0); send_byte('hF0); send_byte('h5A);
        idle(2);
        chk("enter count", en_cnt[0] - base_en, 1);

        // Prefix discarded by reset; reset beats a simultaneous strobe
        do_reset();
        set_ctrl(0, 1, 0);
        send_byte('hF0);
        do_reset();
        send_byte('h16);
        idle(2);
        chk("prefix reset dur", 32'(bus_f.duration_out), 'h0001);
        reset = 1'b1;
        bus_f.key_data  = 8'h1E;
        bus_f.key_valid = 1'b1;
        model_reset();
        idle(1);
        bus_f.key_valid = 1'b0;
        reset = 1'b0;
        idle(1);
        chk("reset over strobe dur", 32'(bus_f.duration_out), 0);
        chk("reset over strobe cnt", 32'(bus_f.digit_count), 0);

        // Randomized traffic
        for (int i = 0; i < 10; i++) begin pool.push_back(top_row[i]); pool.push_back(keypad[i]); end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r, b;
            if (i % 25 == 0)
                set_ctrl(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1);
            r = $urandom_range(0, 99);
            if (r < 55)      b = pool[$urandom_range(0, pool.size() - 1)];
            else if (r < 67) b = 'hF0;
            else if (r < 75) b = 'hE0;
            else if (r < 81) b = 'h5A;
            else if (r < 88) b = 'h66;
            else if (r < 92) b = 'h76;
            else             b = $urandom_range(0, 255);
            send_byte(b);
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("scoreboard filt drained", q_f.size(), 0);
        chk("scoreboard nofilt drained", q_n.size(), 0);
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
